// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings, FSM states
// and the access-size helper.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StAcc0,
    StAcc1,
    StResp
  } state_e;

  // Number of bytes moved by an access of the given funct3.
  function automatic logic [2:0] f3_bytes(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: return 3'd1;
      F3_H, F3_HU: return 3'd2;
      default:     return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane steering for the data-memory responder: store byte enables/lanes across a
// two-word window, and load gather with sign/zero extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_lo_i,
  input  logic [31:0] rword_hi_i,
  output logic [7:0]  be_o,
  output logic [63:0] wlanes_o,
  output logic [31:0] rdata_o
);

  logic [3:0]  size_mask;
  logic [63:0] window;
  logic [31:0] gathered;

  always_comb begin
    case (f3_bytes(funct3_i))
      3'd1:    size_mask = 4'b0001;
      3'd2:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase

    // Bit [3:0] of be_o/wlanes_o map to word N, bits [7:4] to word N+1.
    be_o     = {4'b0000, size_mask} << offset_i;
    wlanes_o = {32'd0, wdata_i} << {offset_i, 3'b000};

    window   = {rword_hi_i, rword_lo_i};
    gathered = window[{offset_i, 3'b000} +: 32];

    case (funct3_i)
      F3_B:    rdata_o = {{24{gathered[7]}}, gathered[7:0]};
      F3_H:    rdata_o = {{16{gathered[15]}}, gathered[15:0]};
      F3_BU:   rdata_o = {24'd0, gathered[7:0]};
      F3_HU:   rdata_o = {16'd0, gathered[15:0]};
      default: rdata_o = gathered;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store data-memory responder with a word-organised, single-port array.
// Define MISALIGN_SPLIT_EN to split misaligned H/W accesses over two words.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

  state_e state_q, state_d;

  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  f3_q;
  logic        err_q;

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rd_lo_q;
  logic [31:0] rd_hi;

  logic [IdxW-1:0] idx0;
  logic [7:0]      be;
  logic [63:0]     wlanes;
  logic [31:0]     load_data;

  logic       accept;
  logic       f3_legal;
  logic       misal;
  logic       req_err;
  logic [2:0] req_size;

  assign idx0 = addr_q[IdxW+1:2];

  always_comb begin
    req_size = f3_bytes(req_funct3);
    if (req_we) begin
      f3_legal = req_funct3 inside {F3_B, F3_H, F3_W};
    end else begin
      f3_legal = req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    end
    misal = ((req_size == 3'd2) && req_addr[0]) ||
            ((req_size == 3'd4) && (req_addr[1:0] != 2'b00));
`ifdef MISALIGN_SPLIT_EN
    req_err = !f3_legal;
`else
    req_err = !f3_legal || misal;
`endif
  end

  assign req_ready = (state_q == StIdle) && !rst;
  assign accept    = req_valid && req_ready;

`ifdef MISALIGN_SPLIT_EN
  logic            split_q;
  logic [31:0]     rd_hi_q;
  logic [IdxW-1:0] idx1;

  assign idx1  = idx0 + IdxW'(1);
  assign rd_hi = rd_hi_q;
`else
  assign rd_hi = '0;
  logic unused_hi;
  assign unused_hi = ^{be[7:4], wlanes[63:32]};
`endif

  logic unused_addr;
  assign unused_addr = ^addr_q[31:IdxW+2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        f3_q    <= req_funct3;
        err_q   <= req_err;
`ifdef MISALIGN_SPLIT_EN
        split_q <= misal;
`endif
      end
    end
  end

  // Array port: no reset on contents; rst blocks any in-flight write.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == StAcc0)) begin
      if (we_q) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem_q[idx0][8*b +: 8] <= wlanes[8*b +: 8];
        end
      end
      rd_lo_q <= mem_q[idx0];
    end
`ifdef MISALIGN_SPLIT_EN
    if (!rst && (state_q == StAcc1)) begin
      if (we_q) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b+4]) mem_q[idx1][8*b +: 8] <= wlanes[32+8*b +: 8];
        end
      end
      rd_hi_q <= mem_q[idx1];
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = req_err ? StResp : StAcc0;
`ifdef MISALIGN_SPLIT_EN
      StAcc0: state_d = split_q ? StAcc1 : StResp;
      StAcc1: state_d = StResp;
`else
      StAcc0: state_d = StResp;
`endif
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  mem_lane_align u_lane_align (
    .funct3_i   (f3_q),
    .offset_i   (addr_q[1:0]),
    .wdata_i    (wdata_q),
    .rword_lo_i (rd_lo_q),
    .rword_hi_i (rd_hi),
    .be_o       (be),
    .wlanes_o   (wlanes),
    .rdata_o    (load_data)
  );

  always_comb begin
    rsp_valid = (state_q == StResp) && !rst;
    rsp_err   = rsp_valid && err_q;
    rsp_rdata = '0;
    if (rsp_valid && !err_q && !we_q) rsp_rdata = load_data;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed requests push expectations,
// a monitor pops and compares each response (data, error flag, latency).
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  data_mem_responder #(
    .DEPTH_WORDS (1024)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rdata 0x%08h err %0b, expected no response",
                 rsp_rdata, rsp_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_rdata"}, rsp_rdata, e.rdata);
        check({e.name, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
        check({e.name, "_lat"}, 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
  end

  task automatic send(input string name, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] f3,
                      input logic [31:0] erd, input logic eerr, input int elat,
                      input bit push);
    int n = 0;
    @(negedge clk);
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_ready_timeout: got req_ready %0b, expected 1", name, req_ready);
      return;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (push) sb.push_back('{name: name, rdata: erd, err: eerr, lat: elat, acc: cyc});
  endtask

  task automatic st(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                    input logic [2:0] f3, input logic eerr, input int elat);
    send(name, 1'b1, addr, wdata, f3, 32'd0, eerr, elat, 1'b1);
  endtask

  task automatic ld(input string name, input logic [31:0] addr, input logic [2:0] f3,
                    input logic [31:0] erd, input logic eerr, input int elat);
    send(name, 1'b0, addr, 32'd0, f3, erd, eerr, elat, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected test end");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_funct3 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);

    st("sw80", 32'h80, 32'hDEADBEEF, 3'b010, 1'b0, 2);
    ld("lw80", 32'h80, 3'b010, 32'hDEADBEEF, 1'b0, 2);
    ld("lb83", 32'h83, 3'b000, 32'hFFFFFFDE, 1'b0, 2);
    ld("lbu83", 32'h83, 3'b100, 32'h000000DE, 1'b0, 2);
    ld("lh82", 32'h82, 3'b001, 32'hFFFFDEAD, 1'b0, 2);
    ld("lhu82", 32'h82, 3'b101, 32'h0000DEAD, 1'b0, 2);
    st("sb81", 32'h81, 32'h11223344, 3'b000, 1'b0, 2);
    ld("lw80_sb", 32'h80, 3'b010, 32'hDEAD44EF, 1'b0, 2);
    ld("ld_f3_011", 32'h80, 3'b011, 32'h0, 1'b1, 1);
    st("st_f3_100", 32'h80, 32'hFFFFFFFF, 3'b100, 1'b1, 1);
    ld("lw80_after_err", 32'h80, 3'b010, 32'hDEAD44EF, 1'b0, 2);
    st("sw84", 32'h84, 32'h0, 3'b010, 1'b0, 2);
    st("sh86", 32'h86, 32'h5555BEEF, 3'b001, 1'b0, 2);
    ld("lh86", 32'h86, 3'b001, 32'hFFFFBEEF, 1'b0, 2);
    ld("lw84", 32'h84, 3'b010, 32'hBEEF0000, 1'b0, 2);
    ld("lbu80", 32'h80, 3'b100, 32'h000000EF, 1'b0, 2);
    st("sw7c", 32'h7C, 32'h11111111, 3'b010, 1'b0, 2);
`ifdef MISALIGN_SPLIT_EN
    st("sw7e", 32'h7E, 32'hCAFEF00D, 3'b010, 1'b0, 3);
    ld("lw7e", 32'h7E, 3'b010, 32'hCAFEF00D, 1'b0, 3);
    ld("lw7c_split", 32'h7C, 3'b010, 32'hF00D1111, 1'b0, 2);
    ld("lw80_split", 32'h80, 3'b010, 32'hDEADCAFE, 1'b0, 2);
    ld("lh7f", 32'h7F, 3'b001, 32'hFFFFFEF0, 1'b0, 3);
`else
    st("sw7e", 32'h7E, 32'hCAFEF00D, 3'b010, 1'b1, 1);
    ld("lw7e", 32'h7E, 3'b010, 32'h0, 1'b1, 1);
    ld("lw7c_nosplit", 32'h7C, 3'b010, 32'h11111111, 1'b0, 2);
    ld("lw80_nosplit", 32'h80, 3'b010, 32'hDEAD44EF, 1'b0, 2);
    ld("lh7f", 32'h7F, 3'b001, 32'h0, 1'b1, 1);
`endif
    st("sw1000", 32'h1000, 32'h12345678, 3'b010, 1'b0, 2);
    ld("lw0_wrap", 32'h0, 3'b010, 32'h12345678, 1'b0, 2);

    // Reset during ACC0 of a store: no response and no write.
    st("sw100", 32'h100, 32'hAAAA5555, 3'b010, 1'b0, 2);
    send("sw100_killed", 1'b1, 32'h100, 32'h0, 3'b010, 32'h0, 1'b0, 0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", {31'd0, req_ready}, 32'd0);
    check("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_rel_ready", {31'd0, req_ready}, 32'd1);
    ld("lw100", 32'h100, 3'b010, 32'hAAAA5555, 1'b0, 2);

    begin
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (4) @(negedge clk);
    check("pending_rsp", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
